// File: rtl/prbs_sync_checker.sv
// Self-synchronising PRBS checker: predicts each bit from received history, flags mismatches,
// tracks lock and (with PRBS_CHECK_ERR_CNT_EN defined) keeps a saturating bit-error count.
module prbs_sync_checker #(
   parameter int unsigned             LFSR_WIDTH   = 31,
   parameter logic [LFSR_WIDTH-1:0]   LFSR_POLY    = 31'h10000001,
   parameter int unsigned             DATA_WIDTH   = 8,
   parameter int unsigned             LOCK_COUNT   = 16,
   parameter int unsigned             UNLOCK_COUNT = 4,
   parameter int unsigned             COUNT_WIDTH  = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [DATA_WIDTH-1:0]  data_in_i,
   input  logic                   data_valid_i,
   input  logic                   clear_i,
   output logic [DATA_WIDTH-1:0]  error_out_o,
   output logic                   error_valid_o,
   output logic                   locked_o,
   output logic [COUNT_WIDTH-1:0] error_count_o
);

   localparam int unsigned PrimeWords = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int unsigned CntMaxA    = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
   localparam int unsigned CntMax     = (CntMaxA > PrimeWords) ? CntMaxA : PrimeWords;
   localparam int unsigned CntW       = $clog2(CntMax + 1);

   // History bit k holds b[n-1-k], so a tap at b[n-W+i] lands on mask bit W-1-i.
   localparam logic [LFSR_WIDTH-1:0] RevPoly = {<<{LFSR_POLY}};
   localparam logic [LFSR_WIDTH-1:0] TapMask = RevPoly | (LFSR_WIDTH'(1) << (LFSR_WIDTH - 1));

   typedef enum logic [1:0] {StPrime, StHunt, StLocked} state_e;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         run_q, run_d;
   logic [LFSR_WIDTH-1:0]   hist_q, hist_d, h_shift;
   logic [DATA_WIDTH-1:0]   d_shift, err_raw, err_word, err_q;
   logic                    err_valid_q;

   // Walk the word MSB first so earlier received bits feed later predictions.
   always_comb begin
      h_shift = hist_q;
      d_shift = data_in_i;
      err_raw = '0;
      for (int j = 0; j < DATA_WIDTH; j++) begin
         err_raw = {err_raw[DATA_WIDTH-2:0], d_shift[DATA_WIDTH-1] ^ (^(h_shift & TapMask))};
         h_shift = {h_shift[LFSR_WIDTH-2:0], d_shift[DATA_WIDTH-1]};
         d_shift = d_shift << 1;
      end
      hist_d   = data_valid_i ? h_shift : hist_q;
      err_word = (state_q == StPrime) ? '0 : err_raw;
   end

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      if (data_valid_i) begin
         unique case (state_q)
            StPrime: begin
               if (run_q == CntW'(PrimeWords - 1)) begin
                  state_d = StHunt;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 1'b1;
               end
            end
            StHunt: begin
               if (|err_raw) begin
                  run_d = '0;
               end else if (run_q == CntW'(LOCK_COUNT - 1)) begin
                  state_d = StLocked;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 1'b1;
               end
            end
            StLocked: begin
               if (!(|err_raw)) begin
                  run_d = '0;
               end else if (run_q == CntW'(UNLOCK_COUNT - 1)) begin
                  state_d = StHunt;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 1'b1;
               end
            end
            default: begin
               state_d = StPrime;
               run_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StPrime;
         run_q       <= '0;
         hist_q      <= '0;
         err_q       <= '0;
         err_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         hist_q      <= hist_d;
         err_valid_q <= data_valid_i;
         if (data_valid_i) err_q <= err_word;
      end
   end

   assign error_out_o   = err_q;
   assign error_valid_o = err_valid_q;
   assign locked_o      = (state_q == StLocked);

`ifdef PRBS_CHECK_ERR_CNT_EN
   logic [COUNT_WIDTH-1:0] ecnt_q, ecnt_d;
   logic [COUNT_WIDTH:0]   ecnt_sum;

   // Clear beats any errors arriving in the same cycle.
   always_comb begin
      ecnt_sum = {1'b0, ecnt_q} + (COUNT_WIDTH + 1)'($countones(err_raw));
      ecnt_d   = ecnt_q;
      if (clear_i) begin
         ecnt_d = '0;
      end else if (data_valid_i && (state_q == StLocked)) begin
         ecnt_d = ecnt_sum[COUNT_WIDTH] ? '1 : ecnt_sum[COUNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ecnt_q <= '0;
      else         ecnt_q <= ecnt_d;
   end

   assign error_count_o = ecnt_q;
`else
   logic unused_clear;
   assign unused_clear  = clear_i;
   assign error_count_o = '0;
`endif

endmodule
